// File: rtl/play_stream_engine.sv
// Playback stream engine: reads a length header, then prefetches samples
// from SDRAM into a small FIFO and offers them to the audio path with
// pause, stop/abort, loop and 1x / 2x-skip / 0.5x-repeat speed modes.
module play_stream_engine #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic [1:0]        play_speed,
  input  logic              play_loop,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_busy,
  output logic              play_done,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic              play_audio_valid,
  output logic [DATA_W-1:0] play_audio_data,
  input  logic              play_audio_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, HDR, RUN, ABORT} state_t;

  state_t                            state;
  logic [ADDR_W-1:0]                 base, addr, remaining, hdr_len;
  logic [1:0]                        speed;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     count;
  logic                              rep;

  logic              fifo_empty, half, accept, pop, push, issue, last_pop;
  logic [ADDR_W-1:0] step;

  assign fifo_empty       = (count == '0);
  assign half             = (speed == 2'b10);
  assign play_busy        = (state != IDLE);
  assign play_addr        = addr;
  assign play_audio_valid = (state == RUN) && !fifo_empty && !play_pause;
  assign play_audio_data  = fifo_empty ? '0 : mem[rd_ptr];
  assign accept           = play_audio_valid && play_audio_ready;
  // 0.5x offers each word twice; the second accept retires it
  assign pop              = accept && (!half || rep);
  assign push             = (state == RUN) && !play_stop && play_read && play_sdram_finished;
  // the outstanding read already owns a slot, so only issue with none pending
  assign issue            = (state == RUN) && !play_read && (remaining != '0) &&
                            (count < CW'(FIFO_DEPTH));
  assign step             = ((speed == 2'b01) && (remaining > ADDR_W'(1))) ? ADDR_W'(2) : ADDR_W'(1);
  // final sample of the stream leaves the FIFO this cycle
  assign last_pop         = pop && (count == CW'(1)) && !play_read && (remaining == '0);

  // prefetch storage, no reset needed: reads are gated by occupancy
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= play_readdata;
  end

  // control FSM, SDRAM request handshake and FIFO bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      base      <= '0;
      addr      <= '0;
      remaining <= '0;
      hdr_len   <= '0;
      speed     <= 2'b00;
      play_read <= 1'b0;
      play_done <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rep       <= 1'b0;
    end else begin
      play_done <= 1'b0;
      case (state)
        IDLE: begin
          if (play_start) begin
            base      <= play_select;
            addr      <= play_select;
            speed     <= play_speed;
            play_read <= 1'b1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (play_stop) begin
            if (play_sdram_finished) begin
              play_read <= 1'b0;
              play_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= ABORT;
            end
          end else if (play_sdram_finished) begin
            play_read <= 1'b0;
            remaining <= play_readdata[ADDR_W-1:0];
            hdr_len   <= play_readdata[ADDR_W-1:0];
            addr      <= base + ADDR_W'(1);
            if (play_readdata[ADDR_W-1:0] == '0) begin
              play_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (play_stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rep    <= 1'b0;
            if (play_read && !play_sdram_finished) begin
              state <= ABORT;
            end else begin
              play_read <= 1'b0;
              play_done <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            if (push) begin
              wr_ptr    <= wr_ptr + PW'(1);
              play_read <= 1'b0;
              addr      <= addr + step;
              remaining <= remaining - step;
            end else if (issue) begin
              play_read <= 1'b1;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + PW'(1);
              rep    <= 1'b0;
            end else if (accept && half) begin
              rep <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (last_pop) begin
              if (play_loop) begin
                addr      <= base + ADDR_W'(1);
                remaining <= hdr_len;
              end else begin
                play_done <= 1'b1;
                state     <= IDLE;
              end
            end
          end
        end
        ABORT: begin
          // hold the request until SDRAM completes, then drop the data
          if (play_sdram_finished) begin
            play_read <= 1'b0;
            play_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_play_stream_engine.sv
// Directed bench for play_stream_engine: SDRAM responder, audio sink
// monitor and queue scoreboards for read addresses and output samples.
module tb_play_stream_engine;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          play_start = 1'b0;
  logic [AW-1:0] play_select = '0;
  logic [1:0]    play_speed = 2'b00;
  logic          play_loop = 1'b0;
  logic          play_pause = 1'b0;
  logic          play_stop = 1'b0;
  logic          play_busy, play_done, play_read, play_audio_valid;
  logic [AW-1:0] play_addr;
  logic [DW-1:0] play_readdata = '0;
  logic          play_sdram_finished = 1'b0;
  logic [DW-1:0] play_audio_data;
  logic          play_audio_ready = 1'b1;

  play_stream_engine #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .play_start(play_start), .play_select(play_select),
    .play_speed(play_speed), .play_loop(play_loop), .play_pause(play_pause),
    .play_stop(play_stop), .play_busy(play_busy), .play_done(play_done),
    .play_read(play_read), .play_addr(play_addr), .play_readdata(play_readdata),
    .play_sdram_finished(play_sdram_finished), .play_audio_valid(play_audio_valid),
    .play_audio_data(play_audio_data), .play_audio_ready(play_audio_ready)
  );

  always #5 i_clk = ~i_clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            fin_cyc = 0;
  int            out_cnt = 0;
  int            lat = 1;
  bit            rd_chk = 1'b1;
  logic [AW-1:0] hdr_addr = '0;
  logic [DW-1:0] hdr_len = '0;
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_out[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dword(input logic [AW-1:0] a);
    return 32'hD000_0000 | {9'd0, a};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return (a == hdr_addr) ? hdr_len : dword(a);
  endfunction

  always @(posedge i_clk) cyc++;

  // SDRAM read port model: completes a held request after lat extra cycles
  initial begin
    int lc = 0;
    forever begin
      @(posedge i_clk); #1;
      play_sdram_finished = 1'b0;
      if (play_read && !i_rst) begin
        if (lc >= lat) begin
          play_sdram_finished = 1'b1;
          play_readdata = mem_rd(play_addr);
          fin_cyc = cyc;
          lc = 0;
          if (rd_chk) begin
            chk("rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) chk("rd_addr", play_addr, exp_rd.pop_front());
          end
        end else lc++;
      end else lc = 0;
    end
  end

  // audio sink monitor and done counter
  initial begin
    forever begin
      @(negedge i_clk);
      if (play_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (play_pause && play_audio_valid) chk("valid_in_pause", play_audio_valid, 0);
      if (play_audio_valid && play_audio_ready) begin
        chk("out_expected", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) chk("out_data", play_audio_data, exp_out.pop_front());
        out_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start(input logic [AW-1:0] sel, input logic [1:0] spd, input logic [DW-1:0] len);
    hdr_addr = sel;
    hdr_len  = len;
    done_cnt = 0;
    out_cnt  = 0;
    play_select = sel;
    play_speed  = spd;
    play_start  = 1'b1;
    tick();
    play_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    tick();
    chk({tag, "_done_width"}, done_cnt, 1);
    chk({tag, "_idle"}, play_busy, 0);
    chk({tag, "_out_drained"}, exp_out.size(), 0);
    chk({tag, "_rd_drained"}, exp_rd.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] held;
    int n;
    repeat (3) tick();
    chk("rst_busy", play_busy, 0);
    chk("rst_done", play_done, 0);
    chk("rst_read", play_read, 0);
    chk("rst_addr", play_addr, 0);
    chk("rst_valid", play_audio_valid, 0);
    chk("rst_data", play_audio_data, 0);
    i_rst = 1'b0;
    tick();

    // 1x, four samples
    lat = 2;
    exp_rd = '{23'h100, 23'h101, 23'h102, 23'h103, 23'h104};
    for (int k = 1; k <= 4; k++) exp_out.push_back(dword(23'h100 + AW'(k)));
    start(23'h100, 2'b00, 32'd4);
    chk("t1_busy", play_busy, 1);
    wait_done("t1", 500);

    // 2x skip over odd length
    lat = 1;
    exp_rd = '{23'h200, 23'h201, 23'h203, 23'h205};
    exp_out = '{dword(23'h201), dword(23'h203), dword(23'h205)};
    start(23'h200, 2'b01, 32'd5);
    wait_done("t2", 500);

    // 0.5x repeat with a jittery sink
    exp_rd = '{23'h400, 23'h401, 23'h402};
    exp_out = '{dword(23'h401), dword(23'h401), dword(23'h402), dword(23'h402)};
    start(23'h400, 2'b10, 32'd2);
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      play_audio_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    play_audio_ready = 1'b1;
    chk("t3_out_cnt", out_cnt, 4);
    wait_done("t3", 10);

    // zero-length header
    exp_rd = '{23'h480};
    start(23'h480, 2'b00, 32'd0);
    wait_done("t4", 200);
    chk("t4_done_latency", done_cyc, fin_cyc + 1);
    chk("t4_no_output", out_cnt, 0);

    // stop while the header read is still pending
    lat = 5;
    exp_rd = '{23'h500};
    start(23'h500, 2'b00, 32'd4);
    tick();
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
    chk("t5_read_held", play_read, 1);
    chk("t5_busy", play_busy, 1);
    chk("t5_no_valid", play_audio_valid, 0);
    wait_done("t5", 200);
    chk("t5_read_dropped", play_read, 0);
    chk("t5_no_output", out_cnt, 0);

    // loop with a pause in the middle
    lat = 1;
    rd_chk = 1'b0;
    play_loop = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int k = 1; k <= 3; k++) exp_out.push_back(dword(23'h700 + AW'(k)));
    start(23'h700, 2'b00, 32'd3);
    n = 0;
    while (out_cnt < 4 && n < 500) begin tick(); n++; end
    chk("t6_reached_pause", out_cnt >= 4, 1);
    play_pause = 1'b1;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_pause_valid", play_audio_valid, 0);
      if (i == 3) held = play_audio_data;
      if (i > 3) chk("t6_pause_hold", play_audio_data, held);
    end
    play_pause = 1'b0;
    n = 0;
    while (out_cnt < 7 && n < 500) begin tick(); n++; end
    chk("t6_loop_no_done", done_cnt, 0);
    play_loop = 1'b0;
    wait_done("t6", 500);
    chk("t6_out_cnt", out_cnt, 9);
    rd_chk = 1'b1;

    // address wrap past the top of SDRAM
    exp_rd = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
    exp_out = '{dword(23'h7FFFFF), dword(23'h000000), dword(23'h000001)};
    start(23'h7FFFFE, 2'b00, 32'd3);
    wait_done("t7", 500);

    // asynchronous reset drops a pending read at once
    lat = 8;
    rd_chk = 1'b0;
    start(23'h600, 2'b00, 32'd4);
    tick();
    chk("t8_read_before", play_read, 1);
    #1 i_rst = 1'b1;
    #1;
    chk("t8_read_async", play_read, 0);
    chk("t8_busy_async", play_busy, 0);
    tick();
    i_rst = 1'b0;
    tick();
    chk("t8_idle", play_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish before limit");
    $fatal(1, "timeout");
  end
endmodule
